polyvec_basemul_acc_ctrl: RTL and testbench

//  Parametrised controller for polyvec base-multiply-accumulate: for K poly pairs it streams
//  RAM A/B into the basemul unit, runs it, and accumulates the products into RAM C. An optional

---
 rtl/polyvec_basemul_acc_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_polyvec_basemul_acc_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyvec_basemul_acc_ctrl.sv
// Sequencer for polyvec base-multiply-accumulate: streams RAM A/B into the basemul core,
// accumulates its products into RAM C for K poly pairs, then optionally runs a REDC pass over C.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | waiting for start
//   S_LOAD     | read LEN words of RAM A/B (bank k_idx) into basemul
//   S_LFLUSH   | RD_LAT cycles for the last loads to land
//   S_CAL      | one-cycle basemul start pulse
//   S_CAL_WAIT | wait for bm_done
//   S_DRAIN    | read LEN products, read old C when k_idx != 0
//   S_DFLUSH   | RD_LAT cycles for the last C writes, then next poly/REDC/FIN
//   S_REDC     | read LEN words of C for the reduction write-back
//   S_RFLUSH   | RD_LAT cycles for the last reduced writes
//   S_FIN      | one-cycle done pulse
module polyvec_basemul_acc_ctrl #(
   parameter  int K      = 3,
   parameter  int LEN    = 128,
   parameter  int RD_LAT = 1,
   localparam int AW     = $clog2(LEN),
   localparam int KW     = (K > 2) ? $clog2(K) : 1
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_start,
   input  logic          i_redc_en,
   input  logic          i_abort,
   input  logic          i_bm_done,
   output logic          o_busy,
   output logic          o_done,
   output logic [KW-1:0] o_k_idx,
   output logic [AW-1:0] o_addr,
   output logic          o_ab_re,
   output logic          o_bm_load_en,
   output logic          o_bm_start,
   output logic          o_bm_rd_en,
   output logic          o_c_re,
   output logic          o_c_we,
   output logic [AW-1:0] o_c_waddr,
   output logic          o_acc_first,
   output logic          o_redc_sel
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_LOAD     = 4'd1;
   localparam logic [3:0] S_LFLUSH   = 4'd2;
   localparam logic [3:0] S_CAL      = 4'd3;
   localparam logic [3:0] S_CAL_WAIT = 4'd4;
   localparam logic [3:0] S_DRAIN    = 4'd5;
   localparam logic [3:0] S_DFLUSH   = 4'd6;
   localparam logic [3:0] S_REDC     = 4'd7;
   localparam logic [3:0] S_RFLUSH   = 4'd8;
   localparam logic [3:0] S_FIN      = 4'd9;

   localparam int FW = 2;
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(RD_LAT - 1);

   logic [3:0]    r_state;
   logic [KW-1:0] r_k_idx;
   logic [AW-1:0] r_addr;
   logic [FW-1:0] r_flush_cnt;
   logic          r_redc_en;

   logic [RD_LAT-1:0] r_ld_pipe;
   logic [RD_LAT-1:0] r_wr_pipe;
   logic [RD_LAT-1:0] r_af_pipe;
   logic [RD_LAT-1:0] r_rs_pipe;
   logic [AW-1:0]     r_wa_pipe [RD_LAT];

   logic w_addr_last;
   logic w_k_last;
   logic w_k_zero;
   logic w_flush_end;
   logic w_ab_re;
   logic w_wr_v;
   logic w_acc_first;
   logic w_redc;
   logic w_c_re;

   assign w_addr_last = (r_addr == AW'(LEN - 1));
   assign w_k_last    = (r_k_idx == KW'(K - 1));
   assign w_k_zero    = (r_k_idx == '0);
   assign w_flush_end = (r_flush_cnt == '0);

   assign w_ab_re     = (r_state == S_LOAD);
   assign w_wr_v      = (r_state == S_DRAIN) || (r_state == S_REDC);
   assign w_acc_first = (r_state == S_DRAIN) && w_k_zero;
   assign w_redc      = (r_state == S_REDC);
   assign w_c_re      = ((r_state == S_DRAIN) && !w_k_zero) || w_redc;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= S_IDLE;
         r_k_idx     <= '0;
         r_addr      <= '0;
         r_flush_cnt <= '0;
         r_redc_en   <= 1'b0;
      end else if (i_abort) begin
         r_state     <= S_IDLE;
         r_k_idx     <= '0;
         r_addr      <= '0;
         r_flush_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state   <= S_LOAD;
                  r_k_idx   <= '0;
                  r_addr    <= '0;
                  r_redc_en <= i_redc_en;
               end
            end
            S_LOAD: begin
               if (w_addr_last) begin
                  r_addr      <= '0;
                  r_flush_cnt <= FLUSH_LOAD;
                  r_state     <= S_LFLUSH;
               end else begin
                  r_addr <= r_addr + AW'(1);
               end
            end
            S_LFLUSH: begin
               if (w_flush_end) r_state <= S_CAL;
               else             r_flush_cnt <= r_flush_cnt - FW'(1);
            end
            S_CAL: r_state <= S_CAL_WAIT;
            S_CAL_WAIT: begin
               if (i_bm_done) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_addr_last) begin
                  r_addr      <= '0;
                  r_flush_cnt <= FLUSH_LOAD;
                  r_state     <= S_DFLUSH;
               end else begin
                  r_addr <= r_addr + AW'(1);
               end
            end
            S_DFLUSH: begin
               if (!w_flush_end) begin
                  r_flush_cnt <= r_flush_cnt - FW'(1);
               end else if (w_k_last) begin
                  r_state <= r_redc_en ? S_REDC : S_FIN;
               end else begin
                  r_k_idx <= r_k_idx + KW'(1);
                  r_state <= S_LOAD;
               end
            end
            S_REDC: begin
               if (w_addr_last) begin
                  r_addr      <= '0;
                  r_flush_cnt <= FLUSH_LOAD;
                  r_state     <= S_RFLUSH;
               end else begin
                  r_addr <= r_addr + AW'(1);
               end
            end
            S_RFLUSH: begin
               if (w_flush_end) r_state <= S_FIN;
               else             r_flush_cnt <= r_flush_cnt - FW'(1);
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_k_idx <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read-side strobes and their attributes travel together so each write sees the
   // address and data-path selects of the read that produced it.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ld_pipe <= '0;
         r_wr_pipe <= '0;
         r_af_pipe <= '0;
         r_rs_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) r_wa_pipe[i] <= '0;
      end else if (i_abort) begin
         r_ld_pipe <= '0;
         r_wr_pipe <= '0;
         r_af_pipe <= '0;
         r_rs_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) r_wa_pipe[i] <= '0;
      end else begin
         r_ld_pipe[0] <= w_ab_re;
         r_wr_pipe[0] <= w_wr_v;
         r_af_pipe[0] <= w_acc_first;
         r_rs_pipe[0] <= w_redc;
         r_wa_pipe[0] <= r_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            r_ld_pipe[i] <= r_ld_pipe[i-1];
            r_wr_pipe[i] <= r_wr_pipe[i-1];
            r_af_pipe[i] <= r_af_pipe[i-1];
            r_rs_pipe[i] <= r_rs_pipe[i-1];
            r_wa_pipe[i] <= r_wa_pipe[i-1];
         end
      end
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_FIN);
   assign o_k_idx      = r_k_idx;
   assign o_addr       = r_addr;
   assign o_ab_re      = w_ab_re;
   assign o_bm_start   = (r_state == S_CAL);
   assign o_bm_rd_en   = (r_state == S_DRAIN);
   assign o_c_re       = w_c_re;
   assign o_bm_load_en = r_ld_pipe[RD_LAT-1];
   assign o_c_we       = r_wr_pipe[RD_LAT-1];
   assign o_c_waddr    = r_wa_pipe[RD_LAT-1];
   assign o_acc_first  = r_af_pipe[RD_LAT-1];
   assign o_redc_sel   = r_rs_pipe[RD_LAT-1];

endmodule

// File: tb/tb_polyvec_basemul_acc_ctrl.sv
// Scoreboard bench: stimulus pushes the expected C writes, basemul starts and done time of
// each run; a negedge monitor pops and compares whenever the controller emits them.
module tb_polyvec_basemul_acc_ctrl;
   localparam int K      = 3;
   localparam int LEN    = 8;
   localparam int RD_LAT = 2;
   localparam int AW     = $clog2(LEN);
   localparam int KW     = (K > 2) ? $clog2(K) : 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          redc_en = 1'b0;
   logic          abort = 1'b0;
   logic          bm_resp = 1'b0;
   logic          bm_stray = 1'b0;
   logic          bm_done;
   logic          o_busy, o_done, o_ab_re, o_bm_load_en, o_bm_start, o_bm_rd_en;
   logic          o_c_re, o_c_we, o_acc_first, o_redc_sel;
   logic [KW-1:0] o_k_idx;
   logic [AW-1:0] o_addr, o_c_waddr;

   assign bm_done = bm_resp | bm_stray;

   polyvec_basemul_acc_ctrl #(.K(K), .LEN(LEN), .RD_LAT(RD_LAT)) dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_redc_en(redc_en),
      .i_abort(abort), .i_bm_done(bm_done),
      .o_busy(o_busy), .o_done(o_done), .o_k_idx(o_k_idx), .o_addr(o_addr),
      .o_ab_re(o_ab_re), .o_bm_load_en(o_bm_load_en), .o_bm_start(o_bm_start),
      .o_bm_rd_en(o_bm_rd_en), .o_c_re(o_c_re), .o_c_we(o_c_we), .o_c_waddr(o_c_waddr),
      .o_acc_first(o_acc_first), .o_redc_sel(o_redc_sel)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int addr;
      bit af;
      bit rs;
      int k;
   } wr_t;

   wr_t q_wr[$];
   int  q_bs[$];
   int  q_done[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  b_arr[K];
   int  n_ab = 0, n_ld = 0, n_rd = 0, n_cre = 0;

   function automatic void chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // basemul core stand-in: done arrives b_arr[k] cycles after bm_start
   int bm_cnt = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         bm_cnt  = 0;
         bm_resp = 1'b0;
      end else if (o_bm_start) begin
         bm_cnt  = b_arr[int'(o_k_idx)];
         bm_resp = 1'b0;
      end else if (bm_cnt > 0) begin
         bm_cnt--;
         bm_resp = (bm_cnt == 0);
      end else begin
         bm_resp = 1'b0;
      end
   end

   logic          ab_hist [RD_LAT] = '{default: 1'b0};
   logic [AW-1:0] addr_hist[RD_LAT] = '{default: '0};
   int            quiet = RD_LAT;

   always @(negedge clk) begin
      wr_t w;
      int  kb;
      if (quiet == 0) chk("bm_load_en_vs_ab_re_delayed", o_bm_load_en, ab_hist[RD_LAT-1]);
      if (o_ab_re)      n_ab++;
      if (o_bm_load_en) n_ld++;
      if (o_bm_rd_en)   n_rd++;
      if (o_c_re)       n_cre++;
      if (o_c_we) begin
         if (q_wr.size() == 0) begin
            chk("unexpected_c_we", o_c_we, 0);
         end else begin
            w = q_wr.pop_front();
            chk("c_waddr", o_c_waddr, w.addr);
            chk("acc_first", o_acc_first, w.af);
            chk("redc_sel", o_redc_sel, w.rs);
            if (!w.rs) chk("write_k_idx", o_k_idx, w.k);
         end
         if (quiet == 0) chk("c_waddr_vs_addr_delayed", o_c_waddr, addr_hist[RD_LAT-1]);
      end
      if (o_bm_start) begin
         if (q_bs.size() == 0) begin
            chk("unexpected_bm_start", o_bm_start, 0);
         end else begin
            kb = q_bs.pop_front();
            chk("bm_start_k_idx", o_k_idx, kb);
         end
      end
      if (o_done) begin
         if (q_done.size() == 0) begin
            chk("unexpected_done", o_done, 0);
         end else begin
            chk("done_cycle", cyc, q_done.pop_front());
            chk("busy_with_done", o_busy, 1);
         end
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
         ab_hist[i]   = ab_hist[i-1];
         addr_hist[i] = addr_hist[i-1];
      end
      ab_hist[0]   = o_ab_re;
      addr_hist[0] = o_addr;
      if (!reset_n || abort) quiet = RD_LAT;
      else if (quiet > 0)    quiet--;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_poly(input int k, input int nwr);
      wr_t w;
      q_bs.push_back(k);
      for (int a = 0; a < nwr; a++) begin
         w.addr = a; w.af = (k == 0); w.rs = 1'b0; w.k = k;
         q_wr.push_back(w);
      end
   endtask

   // Expected run: every poly costs two LEN passes, two flushes, the start pulse and
   // the basemul latency; REDC adds one pass and one flush; FIN adds one cycle.
   task automatic push_run(input bit redc, input int start_c);
      wr_t w;
      int  total = 1;
      for (int k = 0; k < K; k++) begin
         total += 2 * LEN + 2 * RD_LAT + 1 + b_arr[k];
         push_poly(k, LEN);
      end
      if (redc) begin
         total += LEN + RD_LAT;
         for (int a = 0; a < LEN; a++) begin
            w.addr = a; w.af = 1'b0; w.rs = 1'b1; w.k = K - 1;
            q_wr.push_back(w);
         end
      end
      q_done.push_back(start_c + total);
   endtask

   task automatic run_normal(input bit redc, input bit noise);
      int s_ab = n_ab, s_ld = n_ld, s_rd = n_rd, s_cre = n_cre;
      int off = 1;
      int extra_start = $urandom_range(3, 40);
      for (int k = 0; k < K; k++) b_arr[k] = $urandom_range(1, 6);
      start = 1'b1;
      redc_en = redc;
      push_run(redc, cyc);
      tick();
      start = 1'b0;
      redc_en = 1'($urandom_range(0, 1));
      while (q_done.size() > 0 && off < 400) begin
         bm_stray = noise && (off == 2);
         start    = noise && (off == extra_start);
         tick();
         off++;
      end
      bm_stray = 1'b0;
      start = 1'b0;
      if (q_done.size() > 0) begin
         chk("done_timeout_pending", q_done.size(), 0);
         q_done.delete();
      end
      tick();
      chk("busy_after_done", o_busy, 0);
      chk("ab_re_count", n_ab - s_ab, K * LEN);
      chk("bm_load_en_count", n_ld - s_ld, K * LEN);
      chk("bm_rd_en_count", n_rd - s_rd, K * LEN);
      chk("c_re_count", n_cre - s_cre, (K - 1) * LEN + (redc ? LEN : 0));
      chk("writes_left", q_wr.size(), 0);
      chk("bm_starts_left", q_bs.size(), 0);
      q_wr.delete();
      q_bs.delete();
   endtask

   task automatic run_abort(input int j);
      wr_t w;
      bit  hit = 1'b0;
      for (int k = 0; k < K; k++) b_arr[k] = $urandom_range(1, 6);
      push_poly(0, LEN);
      push_poly(1, j + 1);
      start = 1'b1;
      redc_en = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (o_c_we && o_k_idx == KW'(1) && o_c_waddr == AW'(j)) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      chk("abort_point_reached", hit, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("busy_after_abort", o_busy, 0);
      chk("c_we_after_abort", o_c_we, 0);
      chk("addr_after_abort", o_addr, 0);
      chk("k_idx_after_abort", o_k_idx, 0);
      repeat (LEN) tick();
      chk("abort_writes_left", q_wr.size(), 0);
      chk("abort_bm_starts_left", q_bs.size(), 0);
      q_wr.delete();
      q_bs.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_k_idx"}, o_k_idx, 0);
      chk({tag, "_addr"}, o_addr, 0);
      chk({tag, "_strobes"}, {o_ab_re, o_bm_load_en, o_bm_start, o_bm_rd_en, o_c_re, o_c_we}, 0);
      chk({tag, "_c_waddr"}, o_c_waddr, 0);
      chk({tag, "_selects"}, {o_acc_first, o_redc_sel}, 0);
   endtask

   task automatic run_reset_in_cal_wait();
      bit hit = 1'b0;
      for (int k = 0; k < K; k++) b_arr[k] = 5;
      q_bs.push_back(0);
      start = 1'b1;
      redc_en = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (o_bm_start) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      chk("reached_cal", hit, 1);
      tick();
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midrun_reset");
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("reset_bm_starts_left", q_bs.size(), 0);
      q_bs.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset_n = 1'b1;
      tick();
      run_normal(1'b0, 1'b0);
      run_normal(1'b1, 1'b0);
      run_normal(1'b0, 1'b1);
      run_normal(1'b1, 1'b1);
      run_abort($urandom_range(0, LEN - RD_LAT - 1));
      run_normal(1'b1, 1'b0);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start_busy", o_busy, 0);
      repeat (4) tick();
      chk("abort_beats_start_still_idle", o_busy, 0);
      run_reset_in_cal_wait();
      run_normal(1'b0, 1'b1);
      for (int r = 0; r < 4; r++) run_normal(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_abort($urandom_range(0, LEN - RD_LAT - 1));
      run_normal(1'b1, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
